// File: rtl/shift_rows_pipe.sv
// Rijndael ShiftRows / InvShiftRows on an NB-column state behind a valid/ready pipeline stage.
// Optional macro SHIFT_ROWS_PIPE_SKID_EN adds a skid entry and makes in_ready a registered output.
module shift_rows_pipe #(
  parameter int NB = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [0:32*NB-1]  state_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:32*NB-1]  state_out,
  output logic              out_inv
);

  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  // Handshake: a transfer happens on a rising edge where in_valid && in_ready,
  // a delivery where out_valid && out_ready; valid never depends on ready.

  function automatic int row_off(input int r);
    if (r == 0)            return 0;
    else if (NB == 8 && r > 1) return r + 1;
    else                   return r;
  endfunction

  function automatic logic [0:W-1] shift_rows(input logic [0:W-1] s, input logic inv);
    logic [0:W-1] res;
    int           src;
    res = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c - row_off(r) + NB) % NB) : ((c + row_off(r)) % NB);
        res[8*(4*c+r) +: 8] = s[8*(4*src+r) +: 8];
      end
    end
    return res;
  endfunction

  logic [0:W-1] shifted;
  logic         accept;
  logic         out_free;
  logic         out_valid_q;
  logic         out_inv_q;
  logic [0:W-1] out_data_q;

  assign shifted  = shift_rows(state_in, in_inv);
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid_q || out_ready;

`ifdef SHIFT_ROWS_PIPE_SKID_EN
  logic         skid_valid_q;
  logic         skid_valid_d;
  logic         skid_inv_q;
  logic [0:W-1] skid_data_q;
  logic         in_ready_q;
  logic         load_out_skid;
  logic         load_out_in;
  logic         load_skid;

  // in_ready_q mirrors "skid empty", so accept is only ever true with the skid free.
  assign in_ready      = in_ready_q && !rst;
  assign load_out_skid = out_free && skid_valid_q;
  assign load_out_in   = out_free && !skid_valid_q && accept;
  assign load_skid     = !out_free && accept;

  always_comb begin
    skid_valid_d = skid_valid_q;
    if (load_out_skid)  skid_valid_d = 1'b0;
    else if (load_skid) skid_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      if (out_free) out_valid_q <= skid_valid_q || accept;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_out_skid) begin
      out_data_q <= skid_data_q;
      out_inv_q  <= skid_inv_q;
    end else if (load_out_in) begin
      out_data_q <= shifted;
      out_inv_q  <= in_inv;
    end
    if (load_skid) begin
      skid_data_q <= shifted;
      skid_inv_q  <= in_inv;
    end
  end
`else
  assign in_ready = !rst && out_free;

  always_ff @(posedge clk) begin
    if (rst) out_valid_q <= 1'b0;
    else if (out_free) out_valid_q <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      out_data_q <= shifted;
      out_inv_q  <= in_inv;
    end
  end
`endif

  // Data registers are never reset; masking with the valid flag keeps outputs at 0 after reset.
  assign out_valid = out_valid_q;
  assign state_out = out_valid_q ? out_data_q : '0;
  assign out_inv   = out_valid_q && out_inv_q;

endmodule
